// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin APB master.
// Grants one of two local requesters and runs the APB SETUP/ACCESS phases
// against an 8-bit address, 32-bit data slave. It returns read data with a
// one-cycle done pulse, and aborts with rsp_err when the slave stays silent
// for TIMEOUT ACCESS cycles.
// Every output is a flop. Control outputs are loaded from the next-state
// value, so they line up with the state register without any combinational
// path from pready/prdata.

module apb_req_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] req_addr,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_wdata,
  output logic [1:0]  done,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [7:0]  paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  input  logic        pready,
  input  logic [31:0] prdata
);

  // Last counter value before the abort fires. The count runs from 0, so the
  // abort happens on the TIMEOUT-th ACCESS cycle without pready.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_gnt;
  logic        r_last_gnt;
  logic [7:0]  r_cnt;

  logic        r_psel;
  logic        r_penable;
  logic        r_busy;
  logic [1:0]  r_done;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [7:0]  r_paddr;
  logic        r_pwrite;
  logic [31:0] r_pwdata;

  logic        w_gnt;
  logic        w_cmp_ok;
  logic        w_cmp_to;
  logic        w_grant_now;

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;

  assign w_grant_now = (r_state == S_IDLE) && (req != 2'b00);

  // Round-robin pick: a lone requester always wins; under contention the
  // requester that was not served last goes next.
  always_comb begin
    w_gnt = 1'b0;
    case (req)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last_gnt;
      default: w_gnt = 1'b0;
    endcase
  end

  // Next-state logic. It also flags how ACCESS ends: slave response or abort.
  always_comb begin
    w_next   = r_state;
    w_cmp_ok = 1'b0;
    w_cmp_to = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        // pready takes priority over an abort in the same cycle.
        if (pready) begin
          w_next   = S_DONE;
          w_cmp_ok = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next   = S_DONE;
          w_cmp_to = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // APB control strobes and busy, loaded from the next state so they are
  // valid in the same cycle as the state they describe.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
      r_penable <= (w_next == S_ACCESS);
      r_busy    <= (w_next != S_IDLE);
    end
  end

  // Completion pulse to the served requester, one cycle in DONE.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 2'b00;
    end else if (w_next == S_DONE) begin
      r_done <= r_gnt ? 2'b10 : 2'b01;
    end else begin
      r_done <= 2'b00;
    end
  end

  // Grant capture. Request fields are only sampled in IDLE and then held
  // stable across SETUP and ACCESS.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= 1'b0;
      r_paddr  <= 8'h00;
      r_pwrite <= 1'b0;
      r_pwdata <= 32'h0000_0000;
    end else if (w_grant_now) begin
      r_gnt    <= w_gnt;
      r_paddr  <= w_gnt ? req_addr[15:8]   : req_addr[7:0];
      r_pwrite <= w_gnt ? req_write[1]     : req_write[0];
      r_pwdata <= w_gnt ? req_wdata[63:32] : req_wdata[31:0];
    end
  end

  // Round-robin history. It resets to 1 so requester 0 wins the first
  // contention after reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_last_gnt <= r_gnt;
    end
  end

  // ACCESS wait counter: counts cycles without pready and clears in DONE.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h00;
    end else if (r_state == S_DONE) begin
      r_cnt <= 8'h00;
    end else if ((r_state == S_ACCESS) && !pready && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Response capture. It holds until the next transfer completes. Writes and
  // aborts return zero data.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else if (w_cmp_ok) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= r_pwrite ? 32'h0000_0000 : prdata;
    end else if (w_cmp_to) begin
      r_rsp_err   <= 1'b1;
      r_rsp_rdata <= 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Testbench for apb_req_arbiter: a transaction-timeline reference model, an
// APB memory slave with per-transfer wait states, directed scenarios and a
// randomized phase.

module tb_apb_req_arbiter;

  localparam int TIMEOUT = 16;
  localparam int M_MANUAL = 0;
  localparam int M_HOLD   = 1;
  localparam int M_RANDOM = 2;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [1:0]  req_write = 2'b00;
  logic [63:0] req_wdata = 64'h0;
  logic [1:0]  done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'h0;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .done(done),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model. A transfer is a timeline: offset 1 is SETUP, offsets
  // 2..L+1 are ACCESS and offset L+2 is DONE. L is the ACCESS length.
  bit          m_active;
  int          m_k;
  int          m_L;
  bit          m_gnt;
  bit          m_last;
  bit          m_err_t;
  logic [7:0]  m_paddr;
  bit          m_pwrite;
  logic [31:0] m_pwdata;
  bit          m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic [31:0] m_mem [256];
  logic [31:0] s_mem [256];
  int          s_wait;
  int          s_acc;

  int          force_wait = -1;
  int          mode = M_MANUAL;
  bit          drop_all = 1'b0;
  bit          pend [2];
  logic [7:0]  pend_addr [2];
  bit          pend_wr [2];
  logic [31:0] pend_wd [2];

  logic [1:0]  obs_done;
  int          psel_cnt;
  int          pen_cnt;
  logic [7:0]  obs_paddr;
  logic [31:0] obs_pwdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit e_psel();
    return m_active && (m_k <= m_L + 1);
  endfunction

  function automatic bit e_pen();
    return m_active && (m_k >= 2) && (m_k <= m_L + 1);
  endfunction

  function automatic logic [1:0] e_done();
    if (m_active && (m_k == m_L + 2)) return m_gnt ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_L = 0; m_gnt = 0; m_last = 1; m_err_t = 0;
    m_paddr = 8'h0; m_pwrite = 0; m_pwdata = 32'h0;
    m_rsp_err = 0; m_rsp_rdata = 32'h0;
  endtask

  task automatic set_fields(input int i, input logic [7:0] a, input bit w, input logic [31:0] d);
    if (i == 0) begin
      req_addr[7:0] = a; req_write[0] = w; req_wdata[31:0] = d;
    end else begin
      req_addr[15:8] = a; req_write[1] = w; req_wdata[63:32] = d;
    end
  endtask

  // One clock cycle. Check the outputs at the falling edge, then update the
  // requesters and the slave, then advance the model to the next rising edge.
  task automatic step();
    logic [1:0] ed;
    int w;
    @(negedge pclk);
    if (!rst_n) begin
      model_reset();
      req = 2'b00; s_acc = 0; pready = 1'b0;
    end
    check("psel", 64'(psel), 64'(e_psel()));
    check("penable", 64'(penable), 64'(e_pen()));
    check("busy", 64'(busy), 64'(m_active));
    check("done", 64'(done), 64'(e_done()));
    check("paddr", 64'(paddr), 64'(m_paddr));
    check("pwrite", 64'(pwrite), 64'(m_pwrite));
    check("pwdata", 64'(pwdata), 64'(m_pwdata));
    check("rsp_err", 64'(rsp_err), 64'(m_rsp_err));
    check("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_rdata));
    obs_done = done;
    if (psel) begin
      psel_cnt++; obs_paddr = paddr; obs_pwdata = pwdata;
    end
    if (penable) pen_cnt++;
    if (rst_n) begin
      ed = e_done();
      for (int i = 0; i < 2; i++) begin
        if (ed[i] && mode != M_HOLD) req[i] = 1'b0;
      end
      if (drop_all) req = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (pend[i]) begin
          set_fields(i, pend_addr[i], pend_wr[i], pend_wd[i]);
          req[i] = 1'b1; pend[i] = 0;
        end
      end
      if (mode == M_RANDOM) begin
        if (m_active && m_k <= m_L && $urandom_range(0, 15) == 0) req[m_gnt] = 1'b0;
        for (int i = 0; i < 2; i++) begin
          if (!req[i] && !(m_active && m_gnt == i) && $urandom_range(0, 2) == 0) begin
            set_fields(i, 8'($urandom), 1'($urandom), $urandom);
            req[i] = 1'b1;
          end
        end
      end
      if (psel && penable) begin
        s_acc++;
        if (s_acc == s_wait + 1) begin
          pready = 1'b1;
          if (pwrite) s_mem[paddr] = pwdata;
          else prdata = s_mem[paddr];
        end else begin
          pready = 1'b0; prdata = $urandom;
        end
      end else begin
        s_acc = 0; pready = 1'b0; prdata = $urandom;
      end
      if (m_active) begin
        if (m_k == m_L + 2) begin
          m_active = 0; m_last = m_gnt;
        end else begin
          m_k++;
          if (m_k == m_L + 2) begin
            m_rsp_err = m_err_t;
            m_rsp_rdata = (m_err_t || m_pwrite) ? 32'h0 : m_mem[m_paddr];
            if (!m_err_t && m_pwrite) m_mem[m_paddr] = m_pwdata;
          end
        end
      end else if (req != 2'b00) begin
        m_gnt = (req == 2'b11) ? !m_last : req[1];
        m_paddr  = m_gnt ? req_addr[15:8] : req_addr[7:0];
        m_pwrite = m_gnt ? req_write[1] : req_write[0];
        m_pwdata = m_gnt ? req_wdata[63:32] : req_wdata[31:0];
        if (force_wait >= 0) w = force_wait;
        else if ($urandom_range(0, 9) < 7) w = int'($urandom_range(0, 3));
        else w = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
        m_L = (w + 1 < TIMEOUT) ? w + 1 : TIMEOUT;
        m_err_t = (w >= TIMEOUT);
        s_wait = w;
        m_active = 1; m_k = 1;
      end
    end
  endtask

  task automatic wait_done(input string nm, output logic [1:0] d);
    bit seen;
    seen = 0; d = 2'b00;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (obs_done != 2'b00) begin
        d = obs_done; seen = 1;
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s: got no done pulse, expected one within 200 cycles", nm);
    end
  endtask

  task automatic raise(input int i, input logic [7:0] a, input bit w, input logic [31:0] d);
    pend[i] = 1; pend_addr[i] = a; pend_wr[i] = w; pend_wd[i] = d;
  endtask

  initial begin
    logic [1:0] d;
    logic [1:0] order [4];
    bit hit;
    model_reset();
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 32'(i); s_mem[i] = 32'(i);
    end
    s_wait = 0; s_acc = 0; psel_cnt = 0; pen_cnt = 0;

    repeat (2) step();
    check("rst_psel", 64'(psel), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    rst_n = 1'b1;
    step();

    // single write, one wait state
    force_wait = 1; psel_cnt = 0;
    raise(0, 8'h10, 1, 32'hDEADBEEF);
    wait_done("wr_done", d);
    check("wr_done", 64'(d), 64'h1);
    check("wr_err", 64'(rsp_err), 64'h0);
    check("wr_psel_cycles", 64'(psel_cnt), 64'd3);
    check("wr_paddr", 64'(obs_paddr), 64'h10);
    check("wr_pwdata", 64'(obs_pwdata), 64'hDEADBEEF);

    // readback of the written word
    force_wait = 0;
    raise(0, 8'h10, 0, 32'h0);
    wait_done("rb_done", d);
    check("rb_done", 64'(d), 64'h1);
    check("rb_rdata", 64'(rsp_rdata), 64'hDEADBEEF);

    // single read from requester 1
    raise(1, 8'h05, 0, 32'h0);
    wait_done("rd_done", d);
    check("rd_done", 64'(d), 64'h2);
    check("rd_rdata", 64'(rsp_rdata), 64'h5);
    check("rd_err", 64'(rsp_err), 64'h0);

    // contention with both requests held
    mode = M_HOLD;
    raise(0, 8'h03, 0, 32'h0);
    raise(1, 8'h07, 0, 32'h0);
    for (int j = 0; j < 4; j++) wait_done("rr_done", order[j]);
    drop_all = 1; step(); drop_all = 0; mode = M_MANUAL;
    check("rr_order0", 64'(order[0]), 64'h1);
    check("rr_order1", 64'(order[1]), 64'h2);
    check("rr_order2", 64'(order[2]), 64'h1);
    check("rr_order3", 64'(order[3]), 64'h2);

    // timeout: slave never answers
    force_wait = 255; pen_cnt = 0;
    raise(0, 8'h20, 1, 32'h00001234);
    wait_done("to_done", d);
    check("to_done", 64'(d), 64'h1);
    check("to_err", 64'(rsp_err), 64'h1);
    check("to_rdata", 64'(rsp_rdata), 64'h0);
    check("to_access_cycles", 64'(pen_cnt), 64'd16);
    check("to_psel_in_done", 64'(psel), 64'h0);

    // pready on the last allowed ACCESS cycle wins over the abort
    force_wait = TIMEOUT - 1; pen_cnt = 0;
    raise(1, 8'h20, 0, 32'h0);
    wait_done("edge_done", d);
    check("edge_err", 64'(rsp_err), 64'h0);
    check("edge_rdata", 64'(rsp_rdata), 64'h20);
    check("edge_access_cycles", 64'(pen_cnt), 64'd16);

    // reset in the middle of ACCESS
    force_wait = 255;
    raise(1, 8'h30, 1, 32'hCAFEF00D);
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      step();
      if (m_active && m_k >= 3) hit = 1;
    end
    check("mid_penable", 64'(penable), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_psel", 64'(psel), 64'h0);
    check("mid_rst_penable", 64'(penable), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_done", 64'(done), 64'h0);
    step(); step();
    rst_n = 1'b1;
    force_wait = 0; mode = M_HOLD;
    raise(0, 8'h01, 0, 32'h0);
    raise(1, 8'h02, 0, 32'h0);
    wait_done("post_rst_done", d);
    check("post_rst_first_grant", 64'(d), 64'h1);
    drop_all = 1; step(); drop_all = 0; mode = M_MANUAL;

    // randomized traffic
    force_wait = -1; mode = M_RANDOM;
    repeat (3000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-requester APB master. Arbitrates round-robin between two local requesters and sequences the APB SETUP/ACCESS phases toward the 8-bit-address, 32-bit-data APB memory slave.
- Waits for pready, returns read data and a completion pulse to the granted requester.
- Aborts with an error if the slave does not respond within a bounded number of ACCESS cycles.

Parameters:
- TIMEOUT, 16: maximum ACCESS-phase cycles without pready before abort; legal range 1..255.

Ports:
- pclk  in  1  APB clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  request per requester (bit 0 = requester 0); held high until its done pulse
- req_addr  in  16  {addr1[15:8], addr0[7:0]}
- req_write  in  2  1 = write, 0 = read, per requester
- req_wdata  in  64  {wdata1[63:32], wdata0[31:0]}
- done  out  2  one-cycle completion pulse to the served requester
- rsp_err  out  1  valid with done; 1 = timeout abort
- rsp_rdata  out  32  valid with done; read data, 0 for writes or errors
- busy  out  1  high in SETUP, ACCESS, DONE
- paddr  out  8  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  32  APB write data
- pready  in  1  APB ready from slave
- prdata  in  32  APB read data from slave

Behaviour:
- Reset (async, any state, including mid-transfer): state=IDLE; psel, penable, pwrite, paddr, pwdata, done, rsp_err, rsp_rdata, busy all 0; last_grant=1, so requester 0 wins the first contention; timeout counter=0. An in-flight transfer is dropped with no done.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - psel=0, penable=0.
  - If any req bit is high, grant and go to SETUP on the next edge.
  - Single request: that requester is granted.
  - Both requesting: the requester not equal to last_grant is granted.
  - On grant, latch the granted addr/write/wdata into paddr/pwrite/pwdata; store the grant index.
- SETUP (exactly 1 cycle): psel=1, penable=0 -> ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr/pwrite/pwdata are held stable for the whole SETUP+ACCESS span.
  - The timeout counter increments each ACCESS cycle with pready=0.
  - pready=1 sampled at an edge: capture prdata into rsp_rdata if read (0 if write), rsp_err=0, go to DONE.
  - TIMEOUT ACCESS cycles elapsed without pready: rsp_err=1, rsp_rdata=0, go to DONE.
  - pready and the timeout limit in the same cycle: pready wins, no error.
- DONE (exactly 1 cycle):
  - psel=0, penable=0, done[grant]=1; rsp_err and rsp_rdata valid.
  - last_grant <= grant; counter cleared -> IDLE.
  - rsp_rdata/rsp_err hold until the next DONE.
- Requester protocol:
  - The requester deasserts req in the cycle after it samples done.
  - A req still high in IDLE after done is treated as a new request, with round-robin applied.
  - Dropping req mid-transfer does not abort the transfer; done is still issued.
  - req_* inputs are only sampled in IDLE.
- Throughput: minimum 4 cycles per transfer (IDLE, SETUP, ACCESS, DONE); psel is always low for at least 2 cycles between transfers.
- Outputs are registered; no combinational path from pready/prdata to any output.

Test Plan:
- Single write: req=01, addr0=0x10, write0=1, wdata0=0xDEADBEEF, slave pready 1 cycle into ACCESS -> psel high 3 cycles, paddr=0x10, pwdata=0xDEADBEEF; done=01, rsp_err=0; readback of 0x10 returns 0xDEADBEEF.
- Single read: req=10, addr1=0x05, reset-initialised slave -> done=10, rsp_rdata=0x00000005, rsp_err=0.
- Contention: req=11 held continuously (requesters re-raise after done) -> grant order 0,1,0,1; never two consecutive grants to the same requester.
- Timeout: pready tied 0, TIMEOUT=16 -> ACCESS lasts 16 cycles, then done with rsp_err=1, rsp_rdata=0; psel drops in DONE.
- Reset mid-ACCESS: assert rst_n=0 while penable=1 -> psel/penable/busy go 0 asynchronously, no done pulse; first post-reset contention req=11 grants requester 0.
